// File: rtl/uart_pkg.sv
// Shared UART constants: baud select width, the rate table and a ceil-log2 helper.
package uart_pkg;

  localparam int BAUD_SEL_W = 3;
  localparam int MAX_BAUD   = 115200;

  // Rate table indexed by baud_select
  function automatic logic [31:0] baud_rate(input logic [BAUD_SEL_W-1:0] sel);
    logic [31:0] rate;
    case (sel)
      3'd0:    rate = 32'd300;
      3'd1:    rate = 32'd1200;
      3'd2:    rate = 32'd4800;
      3'd3:    rate = 32'd9600;
      3'd4:    rate = 32'd19200;
      3'd5:    rate = 32'd38400;
      3'd6:    rate = 32'd57600;
      default: rate = 32'd115200;
    endcase
    return rate;
  endfunction

  // Ceiling log2, minimum result 1 so a width derived from it is never zero
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// Control and tick bundle between the baud generator and its UART consumers.
interface baud_gen_frac_if #(
  parameter int IDX_W = 4
);
  import uart_pkg::*;

  logic                  en;
  logic [BAUD_SEL_W-1:0] baud_select;
  logic                  align;
  logic                  sample_ENABLE;
  logic                  tx_ENABLE;
  logic                  mid_ENABLE;
  logic [IDX_W-1:0]      sample_idx;
  logic                  baud_changed;

  // Controller side: drives rate/enable/align, consumes ticks
  modport master (
    output en, baud_select, align,
    input  sample_ENABLE, tx_ENABLE, mid_ENABLE, sample_idx, baud_changed
  );

  // Generator side
  modport slave (
    input  en, baud_select, align,
    output sample_ENABLE, tx_ENABLE, mid_ENABLE, sample_idx, baud_changed
  );

endinterface

// File: rtl/baud_gen_frac_div.sv
// Bresenham fractional divider: adds STEP every enabled cycle and wraps at CLK_HZ.
// tick is combinational and marks the cycle in which the accumulator wraps.
module frac_tick_div #(
  parameter int CLK_HZ = 100_000_000,
  parameter int ACC_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [ACC_W-1:0] step,
  output logic             tick
);

  localparam logic [ACC_W:0] MODULUS = (ACC_W+1)'(CLK_HZ);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum;

  // Next accumulator value: clear wins, then add-and-wrap when enabled
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, step};
    acc_d = acc_q;
    tick  = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      if (sum >= MODULUS) begin
        acc_d = ACC_W'(sum - MODULUS);
        tick  = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional UART baud generator: oversample tick, bit tick and mid-bit tick,
// with runtime rate change and start-bit re-alignment.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 32
) (
  input  logic           clk,
  input  logic           reset,
  baud_gen_frac_if.slave bus
);

  localparam int IDX_W = clog2(OVERSAMPLE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);

  // Parameter sanity checks at elaboration
  if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("baud_gen_frac: OVERSAMPLE must be a power of 2 and >= 4");
  end
  if (longint'(MAX_BAUD) * longint'(OVERSAMPLE) > longint'(CLK_HZ) / 2) begin : g_bad_rate
    $error("baud_gen_frac: 115200*OVERSAMPLE exceeds CLK_HZ/2");
  end
  if (ACC_W < 62 && (longint'(2) * longint'(CLK_HZ) >= (longint'(1) << ACC_W))) begin : g_bad_accw
    $error("baud_gen_frac: ACC_W too narrow to hold 2*CLK_HZ");
  end

  logic [BAUD_SEL_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  sample_q, sample_d;
  logic                  tx_q, tx_d;
  logic                  mid_q, mid_d;
  logic                  changed_q, changed_d;

  logic                  baud_change;
  logic                  restart;
  logic                  wrap;
  logic [ACC_W-1:0]      step;

  assign step        = ACC_W'(baud_rate(sel_q) * 32'(OVERSAMPLE));
  assign baud_change = (bus.baud_select != sel_q);
  // A simultaneous align is absorbed by the rate change: one clear either way
  assign restart     = baud_change | bus.align;

  frac_tick_div #(
    .CLK_HZ (CLK_HZ),
    .ACC_W  (ACC_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clear (restart),
    .step  (step),
    .tick  (wrap)
  );

  // Next-state: rate capture, phase counter and tick decode
  always_comb begin
    sel_d     = sel_q;
    idx_d     = idx_q;
    sample_d  = 1'b0;
    tx_d      = 1'b0;
    mid_d     = 1'b0;
    changed_d = baud_change;
    if (baud_change) sel_d = bus.baud_select;
    if (restart) begin
      idx_d = '0;
    end else if (wrap) begin
      sample_d = 1'b1;
      tx_d     = (idx_q == IDX_LAST);
      mid_d    = (idx_q == IDX_MID);
      idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // State and output registers; reset adopts the current select without flagging a change
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= bus.baud_select;
      idx_q     <= '0;
      sample_q  <= 1'b0;
      tx_q      <= 1'b0;
      mid_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      sample_q  <= sample_d;
      tx_q      <= tx_d;
      mid_q     <= mid_d;
      changed_q <= changed_d;
    end
  end

  assign bus.sample_ENABLE = sample_q;
  assign bus.tx_ENABLE     = tx_q;
  assign bus.mid_ENABLE    = mid_q;
  assign bus.sample_idx    = idx_q;
  assign bus.baud_changed  = changed_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac at CLK_HZ=100 MHz, OVERSAMPLE=16.
module tb_baud_gen_frac;

  logic clk = 1'b0;
  logic reset;

  baud_gen_frac_if #(.IDX_W(4)) bif ();

  baud_gen_frac #(
    .CLK_HZ     (100_000_000),
    .OVERSAMPLE (16),
    .ACC_W      (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) begin
      $display("[TB] %s ok: observed %0d", tag, obs);
    end else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] outs();
    return {bif.sample_ENABLE, bif.tx_ENABLE, bif.mid_ENABLE, bif.baud_changed, bif.sample_idx};
  endfunction

  initial begin
    int first, cnt, txc, midc, last, badgap, k, midk, txk, frz, idx_moves;

    // Reset held 3 cycles with sel=3
    reset = 1'b1;
    bif.en = 1'b0;
    bif.align = 1'b0;
    bif.baud_select = 3'd3;
    for (int i = 0; i < 3; i++) begin
      step_edge();
      chk($sformatf("reset_outs_%0d", i), outs(), 0);
    end
    reset = 1'b0;
    step_edge();
    chk("changed_after_release", bif.baud_changed, 0);
    chk("outs_after_release", outs(), 0);

    // 9600 baud: latency and exact count over 15625 enabled edges
    bif.en = 1'b1;
    first = 0; cnt = 0; txc = 0; midc = 0;
    for (int e = 1; e <= 15625; e++) begin
      step_edge();
      if (bif.sample_ENABLE) begin
        cnt++;
        if (first == 0) first = e;
      end
      if (bif.tx_ENABLE) txc++;
      if (bif.mid_ENABLE) midc++;
    end
    chk("9600_first_tick_edge", first, 652);
    chk("9600_sample_count", cnt, 24);
    chk("9600_tx_count", txc, 1);
    chk("9600_mid_count", midc, 2);
    chk("9600_idx_end", bif.sample_idx, 8);

    // Runtime change 3 -> 7 mid-bit, then exact 115200 rate
    bif.baud_select = 3'd7;
    step_edge();
    chk("chg_baud_changed", bif.baud_changed, 1);
    chk("chg_idx", bif.sample_idx, 0);
    chk("chg_no_tick", bif.sample_ENABLE, 0);
    first = 0; cnt = 0; txc = 0; midc = 0; last = 0; badgap = 0;
    for (int e = 1; e <= 15625; e++) begin
      step_edge();
      if (e == 1) chk("chg_pulse_width", bif.baud_changed, 0);
      if (bif.sample_ENABLE) begin
        cnt++;
        if (first == 0) first = e;
        if (last != 0 && (e - last) != 54 && (e - last) != 55) badgap++;
        last = e;
      end
      if (bif.tx_ENABLE) txc++;
      if (bif.mid_ENABLE) midc++;
    end
    chk("115200_first_tick_edge", first, 55);
    chk("115200_sample_count", cnt, 288);
    chk("115200_tx_count", txc, 18);
    chk("115200_mid_count", midc, 18);
    chk("115200_bad_spacing", badgap, 0);

    // Align pulse at idx=9
    k = 0;
    while (bif.sample_idx != 4'd9 && k < 2000) begin
      step_edge();
      k++;
    end
    chk("align_reach_idx9", bif.sample_idx, 9);
    bif.align = 1'b1;
    step_edge();
    bif.align = 1'b0;
    chk("align_idx", bif.sample_idx, 0);
    chk("align_no_tick", bif.sample_ENABLE, 0);
    k = 0; midk = 0; txk = 0; first = 0;
    for (int e = 1; e <= 2000; e++) begin
      step_edge();
      if (bif.sample_ENABLE) begin
        k++;
        if (first == 0) first = e;
        if (bif.mid_ENABLE && midk == 0) midk = k;
        if (bif.tx_ENABLE && txk == 0) txk = k;
      end
      if (txk != 0) break;
    end
    chk("align_first_tick_edge", first, 55);
    chk("align_mid_tick_no", midk, 8);
    chk("align_tx_tick_no", txk, 16);

    // Align coincident with a rate change: single restart at the new rate
    bif.baud_select = 3'd3;
    bif.align = 1'b1;
    step_edge();
    bif.align = 1'b0;
    chk("chg_align_changed", bif.baud_changed, 1);
    chk("chg_align_idx", bif.sample_idx, 0);
    first = 0;
    for (int e = 1; e <= 2000; e++) begin
      step_edge();
      if (e == 1) chk("chg_align_pulse_width", bif.baud_changed, 0);
      if (bif.sample_ENABLE) begin
        first = e;
        break;
      end
    end
    chk("chg_align_first_tick_edge", first, 652);

    // Freeze with en=0 after 3 ticks at 115200
    bif.baud_select = 3'd7;
    step_edge();
    chk("frz_changed", bif.baud_changed, 1);
    cnt = 0;
    for (int e = 1; e <= 170; e++) begin
      step_edge();
      if (bif.sample_ENABLE) cnt++;
    end
    chk("frz_pre_ticks", cnt, 3);
    chk("frz_pre_idx", bif.sample_idx, 3);
    bif.en = 1'b0;
    frz = 0; idx_moves = 0;
    for (int e = 1; e <= 1000; e++) begin
      step_edge();
      if (bif.sample_ENABLE || bif.tx_ENABLE || bif.mid_ENABLE) frz++;
      if (bif.sample_idx != 4'd3) idx_moves++;
    end
    chk("frz_ticks", frz, 0);
    chk("frz_idx_moves", idx_moves, 0);
    bif.en = 1'b1;
    first = 0;
    for (int e = 1; e <= 200; e++) begin
      step_edge();
      if (bif.sample_ENABLE) begin
        first = e;
        break;
      end
    end
    chk("frz_resume_tick_edge", first, 48);

    // Reset on the edge that would have produced the next tick
    cnt = 0;
    for (int e = 1; e <= 53; e++) begin
      step_edge();
      if (bif.sample_ENABLE) cnt++;
    end
    chk("pre_reset_ticks", cnt, 0);
    reset = 1'b1;
    step_edge();
    chk("midbit_reset_outs", outs(), 0);
    reset = 1'b0;
    first = 0;
    for (int e = 1; e <= 200; e++) begin
      step_edge();
      if (bif.sample_ENABLE) begin
        first = e;
        break;
      end
    end
    chk("post_reset_first_tick_edge", first, 55);
    chk("post_reset_changed", bif.baud_changed, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
